sseg_mux_driver: RTL

Multiplexed seven-segment display driver sitting directly downstream of the digit-select ring counter. It consumes the rotating digit-select vector, holds a DIGITS-wide hex value loaded through a valid/ready handshake, and drives registered anode, segment and decimal-point outputs. New values are double-buffered and committed only at a frame boundary, so a scan frame never mixes old and new digits.

---
 rtl/sseg_pkg.sv | 18 +
 rtl/hex2sseg.sv | 11 +
 rtl/sseg_mux_driver.sv | 132 +++++++++++++
 3 files changed

// File: rtl/sseg_pkg.sv
// Shared types and constants for the multiplexed seven-segment driver.
package sseg_pkg;

    localparam int unsigned SEGMENTS = 7;

    // Active-high font, bit order {g,f,e,d,c,b,a}; entry 15 first.
    localparam logic [15:0][SEGMENTS-1:0] HEX_FONT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef enum logic [1:0] {
        StEmpty,
        StShowing,
        StPending
    } state_t;

endpackage

// File: rtl/hex2sseg.sv
// Combinational nibble to active-high seven-segment decoder.
module hex2sseg
    import sseg_pkg::*;
(
    input  logic [3:0]          nibble,
    output logic [SEGMENTS-1:0] seg
);

    assign seg = HEX_FONT[nibble];

endmodule

// File: rtl/sseg_mux_driver.sv
// Multiplexed seven-segment driver with frame-aligned double-buffered loads.
// Optional leading-zero blanking is enabled by defining SSEG_BLANK_EN.
module sseg_mux_driver
    import sseg_pkg::*;
#(
    parameter int unsigned DIGITS     = 4,
    parameter bit          SEL_ACTIVE = 1'b0,
    parameter bit          SEG_ACTIVE = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIGITS-1:0]     sel,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [4*DIGITS-1:0]   load_data,
    input  logic [DIGITS-1:0]     load_dp,
    output logic [DIGITS-1:0]     an,
    output logic [SEGMENTS-1:0]   sseg,
    output logic                  dp,
    output logic                  sel_err
);

    localparam int unsigned IdxW = $clog2(DIGITS);
    localparam logic [SEGMENTS-1:0] SegOff = {SEGMENTS{~SEG_ACTIVE}};

    state_t                state;
    logic [4*DIGITS-1:0]   disp_data, stage_data;
    logic [DIGITS-1:0]     disp_dp, stage_dp, sel_q;

    logic [DIGITS-1:0]     act;
    logic                  sel_ok;
    logic [IdxW-1:0]       idx;
    logic                  boundary;
    logic                  xfer;
    logic [3:0]            nibble;
    logic [SEGMENTS-1:0]   seg_hi;
    logic [DIGITS-1:0]     blank_mask;

    assign load_ready = (state != StPending);
    assign xfer       = load_valid && load_ready;

    always_comb begin
        act    = SEL_ACTIVE ? sel : ~sel;
        sel_ok = (act != '0) && ((act & (act - 1'b1)) == '0);
        idx    = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (act[i]) idx = IdxW'(i);
        end
        // Only a fresh arrival at digit 0 starts a frame; a stalled sel does not.
        boundary = sel_ok && act[0] && (sel != sel_q);
        nibble   = disp_data[4*idx +: 4];
    end

`ifdef SSEG_BLANK_EN
    logic lead;

    always_comb begin
        lead       = 1'b1;
        blank_mask = '0;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            lead          = lead && (disp_data[4*i +: 4] == 4'h0);
            blank_mask[i] = lead;
        end
    end
`else
    assign blank_mask = '0;
`endif

    hex2sseg u_hex2sseg (
        .nibble (nibble),
        .seg    (seg_hi)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StEmpty;
            disp_data  <= '0;
            disp_dp    <= '0;
            stage_data <= '0;
            stage_dp   <= '0;
            sel_q      <= {DIGITS{~SEL_ACTIVE}};
            an         <= {DIGITS{~SEL_ACTIVE}};
            sseg       <= SegOff;
            dp         <= ~SEG_ACTIVE;
            sel_err    <= 1'b0;
        end else begin
            sel_q <= sel;

            unique case (state)
                StEmpty: begin
                    if (xfer) begin
                        disp_data <= load_data;
                        disp_dp   <= load_dp;
                        state     <= StShowing;
                    end
                end
                StShowing: begin
                    if (xfer) begin
                        stage_data <= load_data;
                        stage_dp   <= load_dp;
                        state      <= StPending;
                    end
                end
                StPending: begin
                    if (boundary) begin
                        disp_data <= stage_data;
                        disp_dp   <= stage_dp;
                        state     <= StShowing;
                    end
                end
                default: state <= StEmpty;
            endcase

            // Outputs are built from the display register as it stood before this edge.
            sel_err <= !sel_ok;
            if (!sel_ok) begin
                an   <= {DIGITS{~SEL_ACTIVE}};
                sseg <= SegOff;
                dp   <= ~SEG_ACTIVE;
            end else if (state == StEmpty) begin
                an   <= sel;
                sseg <= SegOff;
                dp   <= ~SEG_ACTIVE;
            end else begin
                an   <= sel;
                sseg <= blank_mask[idx] ? SegOff : (seg_hi ^ SegOff);
                dp   <= disp_dp[idx] ^ ~SEG_ACTIVE;
            end
        end
    end

endmodule
